// File: rtl/clk_divide7_dut.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : clk_divide7_dut
//  Brief    : Divide-by-DIV clock generator with 50% duty cycle. Odd ratios
//             AND a posedge phase register with a negedge-delayed copy, which
//             stretches the low time by half a clock and gives an exact 50%.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_divide7_dut #(
   parameter int DIV = 7
) (
   input  logic clk,
   input  logic rst,          // asynchronous, active-low
   output logic clkDivide7
);

   localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] c_HIGH = CNT_W'((DIV + 1) / 2);

   // Ratios below 2 cannot form a divided clock.
   if (DIV < 2) begin : g_div_check
      $error("clk_divide7_dut: DIV must be >= 2");
   end

   logic [CNT_W-1:0] r_cnt;
   logic             r_p;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Next counter value: wrap from the last count straight back to 0.
   always_comb begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
      if (r_cnt == c_LAST) begin
         w_cnt_nxt = '0;
      end
   end

   // Posedge counter and phase; reset parks the counter at its last value so
   // the first posedge after release lands on count 0.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= c_LAST;
         r_p   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_p   <= (w_cnt_nxt < c_HIGH);
      end
   end

   if ((DIV % 2) == 1) begin : g_odd
      logic r_n;

      // Half-cycle delayed copy of the phase; ANDing both registers delays
      // the rise by half a clock while the fall stays on the posedge.
      always_ff @(negedge clk or negedge rst) begin
         if (!rst) begin
            r_n <= 1'b0;
         end else begin
            r_n <= r_p;
         end
      end

      assign clkDivide7 = r_p & r_n;
   end else begin : g_even
      assign clkDivide7 = r_p;
   end

endmodule
`default_nettype wire

// File: tb/tb_clk_divide7_dut.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_clk_divide7_dut
//  Brief    : Directed bench for clk_divide7_dut with DIV = 7, 4, 3 and 2
//             sharing one clock and reset. Expected waveforms are written as
//             hand-derived edge windows relative to the first counted posedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_divide7_dut;

   logic clk;
   logic rst;
   logic w_out7;
   logic w_out4;
   logic w_out3;
   logic w_out2;

   int n_total;
   int n_bad;

   clk_divide7_dut #(.DIV(7)) u_div7 (.clk(clk), .rst(rst), .clkDivide7(w_out7));
   clk_divide7_dut #(.DIV(4)) u_div4 (.clk(clk), .rst(rst), .clkDivide7(w_out4));
   clk_divide7_dut #(.DIV(3)) u_div3 (.clk(clk), .rst(rst), .clkDivide7(w_out3));
   clk_divide7_dut #(.DIV(2)) u_div2 (.clk(clk), .rst(rst), .clkDivide7(w_out2));

   // 10 ns clock, posedges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
      end
   endtask

   // Expected output level at time t, given the first counted posedge p.
   // Odd ratios: high from p+5 for div*5 ns; even ratios: high from p for div*5 ns.
   function automatic logic exp_level(input int div, input int t, input int p);
      int off;
      if (t < p) return 1'b0;
      off = (t - p) % (div * 10);
      if ((div % 2) == 1) return (off >= 5) && (off < 5 + div * 5);
      return off < div * 5;
   endfunction

   task automatic check_all(input string tag, input int p);
      int t;
      t = int'($time);
      check_val({tag, "_d7"}, {31'd0, w_out7}, {31'd0, exp_level(7, t, p)});
      check_val({tag, "_d4"}, {31'd0, w_out4}, {31'd0, exp_level(4, t, p)});
      check_val({tag, "_d3"}, {31'd0, w_out3}, {31'd0, exp_level(3, t, p)});
      check_val({tag, "_d2"}, {31'd0, w_out2}, {31'd0, exp_level(2, t, p)});
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      rst     = 1'b0;

      // Reset held from t=0: outputs low, counter parked at DIV-1.
      #2;
      check_all("rst_a", 1000);
      #10;
      check_all("rst_b", 1000);
      #4;  // t=16
      check_all("rst_c", 1000);
      check_val("rst_cnt7", {29'd0, u_div7.r_cnt}, 32'd6);

      // Release at t=17; first counted posedge is t=25.
      #1 rst = 1'b1;
      #5;  // t=22
      for (int i = 0; i < 20; i++) begin
         check_all("run1", 25);
         #5;
      end
      // t=122 here; step back to assert reset at t=120 while DIV=7 output is high
      // (high window 100-135). Sampled at 117 above, so rewind via absolute timing.
      rst = 1'b1;
      #0;

      // Now at t=122; reset mid-operation was meant for t=120, so schedule from
      // here: reassert and check the output drops at once.
      rst = 1'b0;
      #1;  // t=123
      check_all("rst_mid", 1000);
      #4;  // t=127
      for (int i = 0; i < 6; i++) begin
         check_all("rst_hold", 1000);
         #5;
      end
      // t=157; release at t=158 so the first counted posedge is t=165.
      #1 rst = 1'b1;
      #4;  // t=162
      for (int i = 0; i < 100; i++) begin
         check_all("run2", 165);
         #5;
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Mid-high-phase reset probe: at t=104 the DIV=7 output must be high
   // (window 100-135); after reassertion at t=122 it is checked low above.
   initial begin
      #104;
      check_val("high_before_rst_d7", {31'd0, w_out7}, 32'd1);
   end

endmodule
`default_nettype wire
